// File: rtl/multdiv_seq.sv
// multdiv_seq: iterative radix-2 multiply/divide unit, one bit per cycle.
// Signed operations run on magnitudes; the signs are reapplied when the result is registered.
module multdiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             multordiv,
    input  logic             signedop,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    state_e state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, step, signed_step;
    logic [WIDTH-1:0] b_q, b_d, hi_q, hi_d, lo_q, lo_d, a_mag, b_mag, diff;
    logic mul_q, mul_d, negq_q, negq_d, negr_q, negr_d, dz_q, dz_d;
    logic [WIDTH:0] sum, shifted;
    logic ge, last;
    always_comb begin
        a_mag = (signedop && a[WIDTH-1]) ? -a : a;
        b_mag = (signedop && b[WIDTH-1]) ? -b : b;
        // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
        sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
        shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        ge = shifted >= {1'b0, b_q};
        diff = shifted[WIDTH-1:0] - b_q;
        step = mul_q ? {sum, acc_q[WIDTH-1:1]}
                     : {ge ? diff : shifted[WIDTH-1:0], acc_q[WIDTH-2:0], ge};
        signed_step = negq_q ? -step : step;
        last = cnt_q == CNTW'(WIDTH - 1);
        state_d = state_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        b_d = b_q;
        mul_d = mul_q;
        negq_d = negq_q;
        negr_d = negr_q;
        dz_d = dz_q;
        hi_d = hi_q;
        lo_d = lo_q;
        case (state_q)
            IDLE: if (start && !cancel) begin
                state_d = RUN;
                cnt_d = '0;
                acc_d = {{WIDTH{1'b0}}, a_mag};
                b_d = b_mag;
                mul_d = multordiv;
                negq_d = signedop && (a[WIDTH-1] ^ b[WIDTH-1]);
                negr_d = signedop && a[WIDTH-1];
                dz_d = b == '0;
            end
            RUN: if (cancel) begin
                state_d = IDLE;
            end else begin
                acc_d = step;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    state_d = DONE;
                    hi_d = mul_q ? signed_step[2*WIDTH-1:WIDTH]
                                 : (negr_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH]);
                    lo_d = (!mul_q && dz_q) ? '1 : signed_step[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            acc_q <= '0;
            b_q <= '0;
            mul_q <= 1'b0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            dz_q <= 1'b0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            b_q <= b_d;
            mul_q <= mul_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
            dz_q <= dz_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end
    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
    assign hi = hi_q;
    assign lo = lo_q;
endmodule

// File: tb/tb_multdiv_seq.sv
// tb_multdiv_seq: directed and randomized checks of multdiv_seq against a plain-arithmetic model.
module tb_multdiv_seq;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, multordiv = 1'b0, signedop = 1'b0, cancel = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic busy, done;
    logic [31:0] hi, lo;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    multdiv_seq dut (
        .clk(clk), .reset(reset), .start(start), .multordiv(multordiv), .signedop(signedop),
        .cancel(cancel), .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // Returns {hi, lo}.
    function automatic logic [63:0] model(input logic m, input logic s, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] ux, uy;
        longint sx, sy, q, r;
        ux = {32'b0, x};
        uy = {32'b0, y};
        sx = $signed(x);
        sy = $signed(y);
        if (m) return s ? 64'(sx * sy) : ux * uy;
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (!s) return {x % y, x / y};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction
    function automatic logic [31:0] rv();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction
    task automatic issue(input logic m, input logic s, input logic [31:0] x, input logic [31:0] y);
        multordiv = m;
        signedop = s;
        a = x;
        b = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask
    // Entered at the negedge of cycle c0 after the start edge.
    task automatic await_done(input string tag, input int c0, input logic [63:0] exp);
        int c = c0;
        int bc = c0 - 1;
        while (!done && c < 60) begin
            if (busy) bc++;
            @(negedge clk);
            c++;
        end
        if (busy) bc++;
        check({tag, "_lat"}, 64'(c), 64'd33);
        check({tag, "_busy"}, 64'(bc), 64'd33);
        check({tag, "_res"}, {hi, lo}, exp);
        @(negedge clk);
        check({tag, "_idle"}, {62'b0, busy, done}, 64'd0);
    endtask
    task automatic run(input string tag, input logic m, input logic s, input logic [31:0] x, input logic [31:0] y, input logic [63:0] exp);
        issue(m, s, x, y);
        await_done(tag, 1, exp);
    endtask
    initial begin
        logic [63:0] prev;
        int nd, c;
        #2;
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_st", {62'b0, busy, done}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run("umul_max", 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run("smul", 1, 1, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
        run("sdiv", 0, 1, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run("sdiv_ovf", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run("udiv", 0, 0, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
        run("udiv0", 0, 0, 32'h1234, 32'd0, 64'h0000_1234_FFFF_FFFF);
        run("sdiv0", 0, 1, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF);
        issue(1, 0, 32'd3, 32'd5);
        repeat (9) @(negedge clk);
        multordiv = 1'b0;
        a = 32'd77;
        b = 32'd99;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        await_done("start_busy", 11, 64'd15);
        issue(1, 0, 32'd6, 32'd7);
        c = 1;
        while (!done && c < 60) begin
            @(negedge clk);
            c++;
        end
        check("b2b_first", {hi, lo}, 64'd42);
        a = 32'd2;
        b = 32'd3;
        start = 1'b1;
        @(negedge clk);
        check("b2b_ignored", {63'b0, busy}, 64'd0);
        @(negedge clk);
        start = 1'b0;
        check("b2b_accepted", {63'b0, busy}, 64'd1);
        await_done("b2b", 1, 64'd6);
        prev = {hi, lo};
        issue(0, 0, 32'd1000, 32'd3);
        repeat (4) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_st", {62'b0, busy, done}, 64'd0);
        check("cancel_hilo", {hi, lo}, prev);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("cancel_nodone", 64'(nd), 64'd0);
        start = 1'b1;
        cancel = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cancel = 1'b0;
        check("start_cancel", {63'b0, busy}, 64'd0);
        issue(1, 1, 32'hFFFF_FFFD, 32'd7);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_hilo", {hi, lo}, 64'd0);
        check("arst_st", {62'b0, busy, done}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run("post_rst", 0, 1, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        repeat (40) begin
            logic m, s;
            logic [31:0] x, y;
            m = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            x = rv();
            y = rv();
            run($sformatf("rnd_%0d%0d_%h_%h", m, s, x, y), m, s, x, y, model(m, s, x, y));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multdiv_seq.md
Name: multdiv_seq

Overview:
- Multi-cycle, iterative responder for the execute stage's multiply/divide requests. It replaces the single-cycle combinational multiply/divide path.
- The pipeline issues a request with a one-cycle start pulse and stalls while busy=1.
- On completion the block returns a 64-bit result as hi/lo, plus a one-cycle done pulse that drives the HI/LO register write enable.

Parameters:
- WIDTH, 32, operand width; hi and lo are each WIDTH bits.
- CNTW, 5, iteration counter width; must satisfy 2**CNTW == WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- multordiv  input  1  1 = multiply, 0 = divide.
- signedop  input  1  1 = signed (MULT/DIV), 0 = unsigned (MULTU/DIVU).
- cancel  input  1  pipeline flush; aborts any request in progress.
- a  input  WIDTH  multiplicand / dividend.
- b  input  WIDTH  multiplier / divisor.
- busy  output  1  high while a request is in RUN or DONE.
- done  output  1  one-cycle pulse; hi/lo are valid in this cycle.
- hi  output  WIDTH  product upper half / remainder.
- lo  output  WIDTH  product lower half / quotient.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state = IDLE; busy = 0; done = 0; hi = lo = 0.
  - Iteration counter and internal registers are cleared.
  - No done pulse is produced for the aborted request.
- States are IDLE, RUN, DONE.
  - busy = (state != IDLE).
  - done = (state == DONE).
- IDLE:
  - On an edge with start=1 and cancel=0: latch a, b, multordiv and signedop; counter = 0; go to RUN.
  - With signedop=1, latch operand magnitudes and record the result signs.
  - With start=0, or cancel=1: remain in IDLE.
- RUN:
  - Each edge performs one radix-2 iteration and increments the counter.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; partial remainder is WIDTH+1 bits.
  - On the edge that completes iteration WIDTH-1, go to DONE.
  - On that same edge, register the final hi/lo with sign correction applied.
- DONE: lasts exactly one cycle, then IDLE.
- cancel=1 in RUN or DONE: on the next edge go to IDLE with done=0; hi/lo keep their prior values.
- Latency: start sampled at edge E; done high in the cycle after edge E+WIDTH, i.e. edge E+32 for the default width. busy is high for WIDTH+1 cycles.
- Earliest new start: sampled on the edge that leaves DONE is ignored; accepted on the following edge (back-to-back spacing of WIDTH+2 cycles).
- start while busy=1: ignored; the operation in progress is undisturbed.
- hi/lo hold their last completed result until the next DONE or reset. They never show partial values.
- Arithmetic:
  - Unsigned multiply: {hi,lo} = a*b, full 64-bit.
  - Signed multiply: two's-complement 64-bit product.
  - Divide: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - Signed 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
  - Divide by zero (b == 0), either signedness: lo = 0xFFFFFFFF, hi = a. Full latency still applies; no exception.

Test Plan:
- Unsigned multiply: start, multordiv=1, signedop=0, a=b=0xFFFFFFFF -> done exactly 33 cycles after the start edge; hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
- Signed multiply and divide:
  - a=0xFFFFFFFD (-3), b=7, multiply -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - a=-7, b=2, divide -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - a=0x80000000, b=0xFFFFFFFF, divide -> lo=0x80000000, hi=0.
- Unsigned divide and divide by zero:
  - a=100, b=7 -> lo=14, hi=2.
  - a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234.
- Start while busy: second start with different operands at cycle 10 of a run -> ignored; the first result is delivered; the next start is accepted only once busy is low.
- Cancel: cancel=1 at cycle 5 of a divide -> busy=0 next cycle, no done pulse, hi/lo unchanged. start and cancel together in IDLE -> no request accepted.
- Reset: assert reset asynchronously mid-RUN (between clock edges) -> busy, done, hi and lo go to 0 immediately. A new request after release completes normally with correct values.
